// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient stage.
package sobel_pkg;

  localparam int DATA_W  = 10;
  localparam int GRAD_W  = 13;
  localparam int PIX_MAX = 1023;

  typedef logic [DATA_W-1:0]        pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]        mag_t;

  function automatic grad_t widen(pixel_t v);
    return grad_t'({{(GRAD_W-DATA_W){1'b0}}, v});
  endfunction

  // |-4092| still fits in 13 bits, so negation cannot overflow.
  function automatic mag_t abs_grad(grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction

  function automatic pixel_t saturate(mag_t m);
    return (m > mag_t'(PIX_MAX)) ? pixel_t'(PIX_MAX) : m[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_gradient_if.sv
// Valid/ready pixel stream used on both sides of the Sobel stage.
interface sobel_gradient_if;
  import sobel_pkg::*;

  logic   valid;
  logic   ready;
  pixel_t data;
  logic   last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sobel_line_buffer.sv
// One-line delay: the word at addr is read out before being replaced by din.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  pixel_t            din,
  output pixel_t            dout
);

  pixel_t mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel magnitude |Gx|+|Gy| over raster-order grayscale pixels.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  sobel_gradient_if.slave  in_s,
  sobel_gradient_if.master out_s
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             stall, accept;
  pixel_t           lb1_q, lb2_q;
  pixel_t           win [3][3];
  logic             s0_valid, s0_last, s1_valid, s1_last;
  grad_t            gx_c, gy_c, gx_q, gy_q;
  logic             out_valid_q, out_last_q;
  pixel_t           out_data_q;

  assign stall      = out_valid_q & ~out_s.ready;
  assign in_s.ready = ~stall & ~rst;
  assign accept     = in_s.valid & in_s.ready;

  assign out_s.valid = out_valid_q;
  assign out_s.data  = out_data_q;
  assign out_s.last  = out_last_q;

  // lb1 holds row-1, lb2 is fed from lb1 and so holds row-2.
  sobel_line_buffer #(.DEPTH(WIDTH), .ADDR_W(COL_W)) u_lb1 (
    .clk(clk), .en(accept), .addr(col), .din(in_s.data), .dout(lb1_q)
  );

  sobel_line_buffer #(.DEPTH(WIDTH), .ADDR_W(COL_W)) u_lb2 (
    .clk(clk), .en(accept), .addr(col), .din(lb1_q), .dout(lb2_q)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_q;
      win[1][2] <= lb1_q;
      win[2][2] <= in_s.data;
    end
  end

  always_comb begin
    gx_c = (widen(win[0][2]) + (widen(win[1][2]) <<< 1) + widen(win[2][2]))
         - (widen(win[0][0]) + (widen(win[1][0]) <<< 1) + widen(win[2][0]));
    gy_c = (widen(win[2][0]) + (widen(win[2][1]) <<< 1) + widen(win[2][2]))
         - (widen(win[0][0]) + (widen(win[0][1]) <<< 1) + widen(win[0][2]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      s0_valid    <= 1'b0;
      s0_last     <= 1'b0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      s0_valid    <= accept && (col >= COL_W'(2)) && (row >= ROW_W'(2));
      s0_last     <= accept && (col == COL_W'(WIDTH-1)) && (row == ROW_W'(HEIGHT-1));
      s1_valid    <= s0_valid;
      s1_last     <= s0_last;
      gx_q        <= gx_c;
      gy_q        <= gy_c;
      out_valid_q <= s1_valid;
      out_last_q  <= s1_last;
      out_data_q  <= saturate(abs_grad(gx_q) + abs_grad(gy_q));
      if (accept) begin
        if (col == COL_W'(WIDTH-1)) begin
          col <= '0;
          row <= (row == ROW_W'(HEIGHT-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
